// File: rtl/uart_rx_fifo.sv
// UART receive path: 2-FF line synchroniser, oversampled receive FSM with runtime
// frame/baud configuration, and a first-word-fall-through RX FIFO with sticky error flags.
module uart_rx_fifo #(
  parameter int TOP_CLK_FREQ_HZ = 50_000_000,
  parameter int OVERSAMPLE      = 16,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          en_i,
  input  logic [1:0]                    baud_sel_i,
  input  logic                          parity_en_i,
  input  logic [1:0]                    stop_width_i,
  input  logic [1:0]                    data_width_i,
  input  logic                          uart_rx_i,
  input  logic                          rd_en_i,
  input  logic                          err_clr_i,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  output logic                          fifo_full_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          parity_err_o,
  output logic                          frame_err_o,
  output logic                          overrun_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(OVERSAMPLE);

  function automatic logic [15:0] calc_div(input int baud);
    int d;
    d = TOP_CLK_FREQ_HZ / (baud * OVERSAMPLE);
    if (d < 1) d = 1;
    return 16'(d);
  endfunction

  localparam logic [15:0] DIV_9600   = calc_div(9600);
  localparam logic [15:0] DIV_19200  = calc_div(19200);
  localparam logic [15:0] DIV_115200 = calc_div(115200);
  localparam logic [15:0] DIV_256000 = calc_div(256000);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q;
  logic [1:0]      sync_q;
  logic [15:0]     div_q;
  logic [15:0]     tick_cnt_q;
  logic [OW-1:0]   os_cnt_q;
  logic [2:0]      last_bit_q;
  logic            par_en_q;
  logic [1:0]      last_stop_q;
  logic [2:0]      bit_idx_q;
  logic [1:0]      stop_idx_q;
  logic [7:0]      data_q;
  logic            par_q;
  logic            par_bad_q;
  logic            frm_bad_q;
  logic            push_q;
  logic [7:0]      push_data_q;
  logic            par_ev_q;
  logic            frm_ev_q;

  logic            line;
  logic            tick;
  logic            mid_bit;
  logic            half_bit;

  assign line     = sync_q[1];
  assign tick     = (tick_cnt_q == div_q - 16'd1);
  assign mid_bit  = tick && (os_cnt_q == OW'(OVERSAMPLE - 1));
  assign half_bit = tick && (os_cnt_q == OW'(OVERSAMPLE / 2 - 1));

  // Receive FSM; frame config is captured on the start edge so later input changes cannot disturb it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      div_q       <= DIV_9600;
      tick_cnt_q  <= '0;
      os_cnt_q    <= '0;
      last_bit_q  <= 3'd7;
      par_en_q    <= 1'b0;
      last_stop_q <= 2'd0;
      bit_idx_q   <= '0;
      stop_idx_q  <= '0;
      data_q      <= '0;
      par_q       <= 1'b0;
      par_bad_q   <= 1'b0;
      frm_bad_q   <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      par_ev_q    <= 1'b0;
      frm_ev_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], uart_rx_i};
      push_q   <= 1'b0;
      par_ev_q <= 1'b0;
      frm_ev_q <= 1'b0;

      if (state_q == IDLE || tick) tick_cnt_q <= '0;
      else                         tick_cnt_q <= tick_cnt_q + 16'd1;

      if (state_q != IDLE && tick) begin
        if (mid_bit || (state_q == START && half_bit)) os_cnt_q <= '0;
        else                                           os_cnt_q <= os_cnt_q + OW'(1);
      end

      if (state_q != IDLE && !en_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            os_cnt_q <= '0;
            if (en_i && !line) begin
              state_q    <= START;
              case (baud_sel_i)
                2'd0:    div_q <= DIV_9600;
                2'd1:    div_q <= DIV_19200;
                2'd2:    div_q <= DIV_115200;
                default: div_q <= DIV_256000;
              endcase
              last_bit_q <= 3'd4 + {1'b0, data_width_i};
              par_en_q   <= parity_en_i;
              case (stop_width_i)
                2'd1:    last_stop_q <= 2'd1;
                2'd2:    last_stop_q <= 2'd2;
                default: last_stop_q <= 2'd0;
              endcase
              bit_idx_q  <= '0;
              stop_idx_q <= '0;
              data_q     <= '0;
              par_q      <= 1'b0;
              par_bad_q  <= 1'b0;
              frm_bad_q  <= 1'b0;
            end
          end
          START: begin
            if (half_bit) state_q <= line ? IDLE : DATA;
          end
          DATA: begin
            if (mid_bit) begin
              data_q[bit_idx_q] <= line;
              par_q             <= par_q ^ line;
              bit_idx_q         <= bit_idx_q + 3'd1;
              if (bit_idx_q == last_bit_q) state_q <= par_en_q ? PARITY : STOP;
            end
          end
          PARITY: begin
            if (mid_bit) begin
              if (line != par_q) par_bad_q <= 1'b1;
              state_q <= STOP;
            end
          end
          STOP: begin
            if (mid_bit) begin
              if (!line) frm_bad_q <= 1'b1;
              stop_idx_q <= stop_idx_q + 2'd1;
              if (stop_idx_q == last_stop_q) begin
                state_q     <= IDLE;
                push_q      <= !par_bad_q && !frm_bad_q && line;
                push_data_q <= data_q;
                par_ev_q    <= par_bad_q;
                frm_ev_q    <= frm_bad_q || !line;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full;
  logic          pop;
  logic          wr_ok;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign pop   = rd_en_i && (count_q != '0);
  assign wr_ok = push_q && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= push_data_q;
  end

  // A push into a full FIFO only succeeds when the head is popped in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({wr_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      parity_err_o <= par_ev_q || (parity_err_o && !err_clr_i);
      frame_err_o  <= frm_ev_q || (frame_err_o && !err_clr_i);
      overrun_o    <= (push_q && full && !pop) || (overrun_o && !err_clr_i);
    end
  end

  assign rx_valid_o   = (count_q != '0);
  assign fifo_full_o  = full;
  assign fifo_count_o = count_q;
  assign rx_data_o    = rx_valid_o ? mem_q[rd_ptr_q] : 8'h00;

endmodule
